// File: rtl/bus_decoder.sv
// Purpose : processor-bus address decoder with memory/IO chip selects, read-data steering and ready/bus_error handshake.
// Latency : selects combinational; memory ready MEM_WAIT cycles after request, IO write 1 cycle, IO read on device valid or bus_error after IO_TIMEOUT.
// Backpress: CPU holds read/write until ready/bus_error; a held request never retriggers until both drop.
//
// Ports:
//   clock, reset                     clock and synchronous active-high reset
//   address[29:0]                    word address (byte address [31:2])
//   read, write                      CPU requests, held until completion
//   region_cs / io_cs                one-hot selects, decoded from address only
//   region_data_in / io_data_in      packed per-target read data, target n at [32n+31:32n]
//   io_data_valid                    per-device read data valid
//   data_out                         registered read data, updated only by successful reads
//   ready, bus_error                 single-cycle completion pulses
// Optional feature macro: BUS_DECODER_STATS_EN adds error_count and error_address.
module bus_decoder #(
    parameter int          NUM_REGIONS = 4,
    parameter int          NUM_IO      = 16,
    parameter logic [7:0]  IO_CLASS    = 8'h0f,
    parameter int          MEM_WAIT    = 1,
    parameter int          IO_TIMEOUT  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [29:0]                address,
    input  logic                       read,
    input  logic                       write,
    output logic [NUM_REGIONS-1:0]     region_cs,
    output logic [NUM_IO-1:0]          io_cs,
    input  logic [32*NUM_REGIONS-1:0]  region_data_in,
    input  logic [32*NUM_IO-1:0]       io_data_in,
    input  logic [NUM_IO-1:0]          io_data_valid,
    output logic [31:0]                data_out,
    output logic                       ready,
`ifdef BUS_DECODER_STATS_EN
    output logic                       bus_error,
    output logic [15:0]                error_count,
    output logic [29:0]                error_address
`else
    output logic                       bus_error
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] MEM_LAST = 8'(MEM_WAIT - 1);
    localparam logic [7:0] IO_LAST  = 8'(IO_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic        r_is_write;
    logic [31:0] r_data_out;

    logic [7:0]  w_hi;
    logic [5:0]  w_idx;
    logic        w_is_mem;
    logic        w_is_io;
    logic [31:0] w_mem_dat;
    logic [31:0] w_io_dat;
    logic        w_io_vld;
    logic        w_ready;
    logic        w_error;
    logic        w_cap;
    logic [31:0] w_cap_dat;
    logic        w_unused;

    // Byte address [23:8] plays no part in decoding.
    assign w_unused = ^address[21:6];

    assign w_hi     = address[29:22];
    assign w_idx    = address[5:0];
    assign w_is_mem = int'(w_hi) < NUM_REGIONS;
    // Memory decode wins if IO_CLASS ever overlaps the region range, keeping selects one-hot.
    assign w_is_io  = !w_is_mem && (w_hi == IO_CLASS) && (int'(w_idx) < NUM_IO);

    always_comb begin
        region_cs = '0;
        w_mem_dat = '0;
        for (int n = 0; n < NUM_REGIONS; n++) begin
            if (int'(w_hi) == n) begin
                region_cs[n] = 1'b1;
                w_mem_dat    = region_data_in[32*n +: 32];
            end
        end
    end

    always_comb begin
        io_cs    = '0;
        w_io_dat = '0;
        w_io_vld = 1'b0;
        for (int n = 0; n < NUM_IO; n++) begin
            if (w_is_io && (int'(w_idx) == n)) begin
                io_cs[n] = 1'b1;
                w_io_dat = io_data_in[32*n +: 32];
                w_io_vld = io_data_valid[n];
            end
        end
    end

    // Completion pulses are driven during the final ACCESS cycle so the CPU sees
    // ready in the same cycle a device raises its valid; read data lands in
    // data_out on the edge that closes that cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_error     = 1'b0;
        w_cap       = 1'b0;
        w_cap_dat   = w_mem_dat;
        case (r_state)
            S_IDLE: begin
                if (read || write) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!w_is_mem && !w_is_io) begin
                    w_error     = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_is_mem) begin
                    if (r_cnt == MEM_LAST) begin
                        w_ready     = 1'b1;
                        w_cap       = !r_is_write;
                        w_state_nxt = S_DONE;
                    end
                end else if (r_is_write) begin
                    w_ready     = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_io_vld) begin
                    // Valid in the timeout cycle still completes successfully.
                    w_ready     = 1'b1;
                    w_cap       = 1'b1;
                    w_cap_dat   = w_io_dat;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == IO_LAST) begin
                    w_error     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!read && !write) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && (read || write)) begin
                r_cnt      <= '0;
                // Simultaneous read and write is handled as a write.
                r_is_write <= write;
            end else if (r_state == S_ACCESS && r_cnt != 8'hff) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_cap) begin
                r_data_out <= w_cap_dat;
            end
        end
    end

    // Gating with reset drops any pulse from an access being abandoned this cycle.
    assign ready     = w_ready & ~reset;
    assign bus_error = w_error & ~reset;
    assign data_out  = r_data_out;

`ifdef BUS_DECODER_STATS_EN
    logic [15:0] r_error_count;
    logic [29:0] r_error_address;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_error_count   <= '0;
            r_error_address <= '0;
        end else if (w_error) begin
            if (r_error_count != 16'hffff) begin
                r_error_count <= r_error_count + 16'd1;
            end
            r_error_address <= address;
        end
    end

    assign error_count   = r_error_count;
    assign error_address = r_error_address;
`endif

endmodule

// File: tb/tb_bus_decoder.sv
// Purpose : directed self-checking bench for bus_decoder with default parameters.
// Latency : cycle counts are measured from the cycle in which the request is raised.
// Backpress: requests are held until ready/bus_error, then held two more cycles before release.
module tb_bus_decoder;

    logic          clock;
    logic          reset;
    logic [29:0]   address;
    logic          read;
    logic          write;
    logic [3:0]    region_cs;
    logic [15:0]   io_cs;
    logic [127:0]  region_data_in;
    logic [511:0]  io_data_in;
    logic [15:0]   io_data_valid;
    logic [31:0]   data_out;
    logic          ready;
    logic          bus_error;
`ifdef BUS_DECODER_STATS_EN
    logic [15:0]   error_count;
    logic [29:0]   error_address;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bus_decoder dut (
        .clock          (clock),
        .reset          (reset),
        .address        (address),
        .read           (read),
        .write          (write),
        .region_cs      (region_cs),
        .io_cs          (io_cs),
        .region_data_in (region_data_in),
        .io_data_in     (io_data_in),
        .io_data_valid  (io_data_valid),
        .data_out       (data_out),
        .ready          (ready),
`ifdef BUS_DECODER_STATS_EN
        .bus_error      (bus_error),
        .error_count    (error_count),
        .error_address  (error_address)
`else
        .bus_error      (bus_error)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raises the request, optionally raises io_data_valid[v_idx] v_at cycles later
    // (v_at < 0 never), and returns the cycle on which ready or bus_error appeared.
    task automatic do_access(input logic [29:0] a, input logic rd, input logic wr,
                             input int v_idx, input int v_at,
                             output int cyc, output logic got_rdy, output logic got_err);
        @(posedge clock); #1;
        address       = a;
        read          = rd;
        write         = wr;
        io_data_valid = '0;
        cyc     = 0;
        got_rdy = 1'b0;
        got_err = 1'b0;
        forever begin
            if (cyc == v_at) io_data_valid[v_idx] = 1'b1;
            @(negedge clock);
            if (ready || bus_error) begin
                got_rdy = ready;
                got_err = bus_error;
                break;
            end
            if (cyc >= 100) break;
            @(posedge clock); #1;
            cyc++;
        end
    endtask

    // Holds the request two more cycles (must not retrigger), then releases it.
    task automatic finish_access(input string tag);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            @(negedge clock);
            check({tag, "_hold_pulse"}, {62'd0, ready, bus_error}, 64'd0);
        end
        @(posedge clock); #1;
        read          = 1'b0;
        write         = 1'b0;
        io_data_valid = '0;
        @(posedge clock); #1;
    endtask

    int   cyc;
    logic rdy;
    logic err;

    initial begin
        reset          = 1'b1;
        address        = '0;
        read           = 1'b0;
        write          = 1'b0;
        io_data_valid  = '0;
        region_data_in = {32'h1000_0003, 32'h1000_0002, 32'hdead_beef, 32'h1000_0000};
        for (int n = 0; n < 16; n++) io_data_in[32*n +: 32] = 32'ha000_0000 + 32'(n);
        io_data_in[63:32] = 32'h0000_001c;

        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("reset_data_out", data_out, 64'd0);
        check("reset_ready", ready, 64'd0);
        check("reset_bus_error", bus_error, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // 1: memory read region 1
        do_access(30'h0040_0000, 1'b1, 1'b0, 0, -1, cyc, rdy, err);
        check("t1_region_cs", region_cs, 64'h2);
        check("t1_io_cs", io_cs, 64'h0);
        check("t1_cycles", cyc, 64'd1);
        check("t1_ready_err", {rdy, err}, 64'h2);
        finish_access("t1");
        check("t1_data_out", data_out, 64'hdead_beef);

        // 2: IO write to device 6
        do_access(30'h03c0_0006, 1'b0, 1'b1, 0, -1, cyc, rdy, err);
        check("t2_io_cs", io_cs, 64'h0040);
        check("t2_region_cs", region_cs, 64'h0);
        check("t2_cycles", cyc, 64'd1);
        check("t2_ready_err", {rdy, err}, 64'h2);
        finish_access("t2");
        check("t2_data_out", data_out, 64'hdead_beef);

        // 3: IO read device 1, valid 5 cycles after start
        do_access(30'h03c0_0001, 1'b1, 1'b0, 1, 5, cyc, rdy, err);
        check("t3_io_cs", io_cs, 64'h0002);
        check("t3_cycles", cyc, 64'd5);
        check("t3_ready_err", {rdy, err}, 64'h2);
        finish_access("t3");
        check("t3_data_out", data_out, 64'h1c);

        // 4: IO read device 2 with no valid -> timeout
        do_access(30'h03c0_0002, 1'b1, 1'b0, 0, -1, cyc, rdy, err);
        check("t4_cycles", cyc, 64'd32);
        check("t4_ready_err", {rdy, err}, 64'h1);
        finish_access("t4");
        check("t4_data_out", data_out, 64'h1c);
`ifdef BUS_DECODER_STATS_EN
        check("t4_error_count", error_count, 64'd1);
`endif

        // 5: unmapped high byte 0x07
        do_access(30'h01c0_0000, 1'b1, 1'b0, 0, -1, cyc, rdy, err);
        check("t5_selects", {region_cs, io_cs}, 64'h0);
        check("t5_cycles", cyc, 64'd1);
        check("t5_ready_err", {rdy, err}, 64'h1);
        finish_access("t5");
        check("t5_data_out", data_out, 64'h1c);
`ifdef BUS_DECODER_STATS_EN
        check("t5_error_count", error_count, 64'd2);
        check("t5_error_address", error_address, 64'h01c0_0000);
`endif

        // IO class with device index beyond NUM_IO is unmapped
        do_access(30'h03c0_0014, 1'b1, 1'b0, 0, -1, cyc, rdy, err);
        check("oor_selects", {region_cs, io_cs}, 64'h0);
        check("oor_ready_err", {rdy, err}, 64'h1);
        finish_access("oor");

        // Last region, read and write together behave as a write
        do_access(30'h00c0_0000, 1'b1, 1'b1, 0, -1, cyc, rdy, err);
        check("rw_region_cs", region_cs, 64'h8);
        check("rw_ready_err", {rdy, err}, 64'h2);
        finish_access("rw");
        check("rw_data_out", data_out, 64'h1c);

        do_access(30'h00c0_0000, 1'b1, 1'b0, 0, -1, cyc, rdy, err);
        check("r3_cycles", cyc, 64'd1);
        finish_access("r3");
        check("r3_data_out", data_out, 64'h1000_0003);

        // 6: reset during an IO read wait; valid raised in the reset cycle must not complete it
        @(posedge clock); #1;
        address = 30'h03c0_0001;
        read    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t6_wait_pulse", {62'd0, ready, bus_error}, 64'd0);
            @(posedge clock); #1;
        end
        reset            = 1'b1;
        read             = 1'b0;
        io_data_valid[1] = 1'b1;
        @(negedge clock);
        check("t6_reset_pulse", {62'd0, ready, bus_error}, 64'd0);
        @(posedge clock); #1;
        reset         = 1'b0;
        io_data_valid = '0;
        @(negedge clock);
        check("t6_data_out", data_out, 64'd0);
        check("t6_after_pulse", {62'd0, ready, bus_error}, 64'd0);
`ifdef BUS_DECODER_STATS_EN
        check("t6_error_count", error_count, 64'd0);
`endif
        do_access(30'h0040_0000, 1'b1, 1'b0, 0, -1, cyc, rdy, err);
        check("t6_next_cycles", cyc, 64'd1);
        check("t6_next_ready_err", {rdy, err}, 64'h2);
        finish_access("t6n");
        check("t6_next_data_out", data_out, 64'hdead_beef);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
